// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches over imem req/ack, issues to decode
// over valid/ready, and commits npc_in only when decode accepts. Adds halt, timeout, retire count.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] npc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    input  logic        instr_ready,
    input  logic        stall,
    input  logic        halt_req,
    output logic        halted,
    output logic        fetch_err,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_ISSUE,
        S_HALT
    } state_t;

    localparam logic [31:0] LP_WAIT_LAST = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retire;
    logic [31:0] r_wait;
    logic        r_halt_pend;
    logic        r_fetch_err;

    logic w_accept;
    logic w_timeout;

    assign w_accept  = (r_state == S_ISSUE) && instr_ready && !stall;
    assign w_timeout = (TIMEOUT != 0) && (r_wait == LP_WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RESET;
            r_pc        <= RESET_PC;
            r_instr     <= 32'd0;
            r_retire    <= 32'd0;
            r_wait      <= 32'd0;
            r_halt_pend <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            // Set first so that a same-cycle entry into HALT below overrides it.
            if (halt_req && (r_state != S_HALT)) begin
                r_halt_pend <= 1'b1;
            end
            case (r_state)
                S_RESET: begin
                    r_state <= S_FETCH;
                    r_wait  <= 32'd0;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= S_ISSUE;
                    end else if (w_timeout) begin
                        r_fetch_err <= 1'b1;
                        r_halt_pend <= 1'b0;
                        r_state     <= S_HALT;
                    end else begin
                        r_wait <= r_wait + 32'd1;
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        r_pc     <= npc_in;
                        r_retire <= r_retire + 32'd1;
                        if (r_halt_pend || halt_req) begin
                            r_halt_pend <= 1'b0;
                            r_state     <= S_HALT;
                        end else begin
                            r_wait  <= 32'd0;
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign imem_addr   = r_pc;
    assign imem_req    = (r_state == S_FETCH);
    assign instr_valid = (r_state == S_ISSUE);
    assign instr_out   = r_instr;
    assign halted      = (r_state == S_HALT);
    assign fetch_err   = r_fetch_err;
    assign retire_cnt  = r_retire;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential run, wait states/backpressure, redirect,
// halt, timeout and reset mid-fetch, each checked against hand-computed values.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] npc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic        instr_ready;
    logic        stall;
    logic        halt_req;
    logic        halted;
    logic        fetch_err;
    logic [31:0] retire_cnt;

    logic        jump_en;
    logic [31:0] jump_pc;
    logic        junk_data;

    int checks = 0;
    int errors = 0;

    // Next-PC unit and memory: sequential increment unless redirected; word = 0xA0000000 | addr.
    assign npc_in     = jump_en ? jump_pc : pc_out + 32'd1;
    assign imem_rdata = junk_data ? 32'hDEAD_BEEF : (32'hA000_0000 | imem_addr);

    fetch_sequencer #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_out     (pc_out),
        .npc_in     (npc_in),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_out  (instr_out),
        .instr_ready(instr_ready),
        .stall      (stall),
        .halt_req   (halt_req),
        .halted     (halted),
        .fetch_err  (fetch_err),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset;
        imem_ack = 1'b0; instr_ready = 1'b0; stall = 1'b0; halt_req = 1'b0;
        jump_en = 1'b0; jump_pc = 32'd0; junk_data = 1'b0;
        apply_reset();
        checks++;
        if (pc_out !== 32'd0 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL reset_pc: pc=%h addr=%h required 0", pc_out, imem_addr);
        end
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr_out !== 32'd0) begin
            errors++; $display("FAIL reset_outs: req=%b valid=%b instr=%h required 0/0/0", imem_req, instr_valid, instr_out);
        end
        checks++;
        if (retire_cnt !== 32'd0 || halted !== 1'b0 || fetch_err !== 1'b0) begin
            errors++; $display("FAIL reset_status: retire=%0d halted=%b err=%b required 0/0/0", retire_cnt, halted, fetch_err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL first_req: req=%b required 1", imem_req);
        end
        $display("reset: pc=%h req=%b", pc_out, imem_req);
    endtask

    task automatic test_sequential;
        imem_ack = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_out !== 32'(i) || imem_req !== 1'b1) begin
                errors++; $display("FAIL seq_fetch%0d: pc=%h req=%b required %h/1", i, pc_out, imem_req, 32'(i));
            end
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== (32'hA000_0000 + 32'(i))) begin
                errors++; $display("FAIL seq_issue%0d: valid=%b instr=%h required 1/%h", i, instr_valid, instr_out, 32'hA000_0000 + 32'(i));
            end
            tick();
            $display("seq: accepted pc=%0d now pc=%h retire=%0d", i, pc_out, retire_cnt);
        end
        checks++;
        if (retire_cnt !== 32'd4 || pc_out !== 32'd4) begin
            errors++; $display("FAIL seq_retire: retire=%0d pc=%h required 4/4", retire_cnt, pc_out);
        end
    endtask

    task automatic test_wait_backpressure;
        imem_ack = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || instr_valid !== 1'b0) begin
                errors++; $display("FAIL wait%0d: req=%b valid=%b required 1/0", i, imem_req, instr_valid);
            end
        end
        imem_ack = 1'b1;  // fourth FETCH cycle: ack must beat the timeout
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hA000_0004 || fetch_err !== 1'b0) begin
            errors++; $display("FAIL ack_wins: valid=%b instr=%h err=%b required 1/a0000004/0", instr_valid, instr_out, fetch_err);
        end
        junk_data = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'hA000_0004 || pc_out !== 32'd4) begin
                errors++; $display("FAIL not_ready%0d: valid=%b instr=%h pc=%h required 1/a0000004/4", i, instr_valid, instr_out, pc_out);
            end
        end
        instr_ready = 1'b1; stall = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hA000_0004 || pc_out !== 32'd4) begin
            errors++; $display("FAIL stall_hold: valid=%b instr=%h pc=%h required 1/a0000004/4", instr_valid, instr_out, pc_out);
        end
        stall = 1'b0; imem_ack = 1'b0; junk_data = 1'b0;
        tick();
        checks++;
        if (pc_out !== 32'd5 || imem_req !== 1'b1 || retire_cnt !== 32'd5) begin
            errors++; $display("FAIL bp_accept: pc=%h req=%b retire=%0d required 5/1/5", pc_out, imem_req, retire_cnt);
        end
        $display("backpressure: accepted pc=4 now pc=%h retire=%0d", pc_out, retire_cnt);
    endtask

    task automatic test_redirect;
        imem_ack = 1'b1; jump_en = 1'b1; jump_pc = 32'h40;
        tick(); tick();
        checks++;
        if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin
            errors++; $display("FAIL jump: addr=%h req=%b required 40/1", imem_addr, imem_req);
        end
        jump_pc = 32'h12;
        tick();
        checks++;
        if (instr_out !== 32'hA000_0040) begin
            errors++; $display("FAIL jump_word: instr=%h required a0000040", instr_out);
        end
        tick();
        checks++;
        if (imem_addr !== 32'h12 || imem_req !== 1'b1) begin
            errors++; $display("FAIL jr: addr=%h req=%b required 12/1", imem_addr, imem_req);
        end
        jump_pc = 32'h7;
        tick(); tick();
        jump_en = 1'b0;
        checks++;
        if (pc_out !== 32'h7 || retire_cnt !== 32'd8) begin
            errors++; $display("FAIL redirect_end: pc=%h retire=%0d required 7/8", pc_out, retire_cnt);
        end
        $display("redirect: 5->40->12->7 retire=%0d", retire_cnt);
    endtask

    task automatic test_halt;
        imem_ack = 1'b0; instr_ready = 1'b1; halt_req = 1'b1;
        tick();
        halt_req = 1'b0; imem_ack = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hA000_0007 || halted !== 1'b0) begin
            errors++; $display("FAIL halt_issue: valid=%b instr=%h halted=%b required 1/a0000007/0", instr_valid, instr_out, halted);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || pc_out !== 32'h8 || imem_req !== 1'b0 || retire_cnt !== 32'd9) begin
            errors++; $display("FAIL halt_enter: halted=%b pc=%h req=%b retire=%0d required 1/8/0/9", halted, pc_out, imem_req, retire_cnt);
        end
        tick(); tick(); tick();
        checks++;
        if (halted !== 1'b1 || pc_out !== 32'h8 || imem_req !== 1'b0 || instr_valid !== 1'b0 || retire_cnt !== 32'd9) begin
            errors++; $display("FAIL halt_stay: halted=%b pc=%h req=%b valid=%b retire=%0d required 1/8/0/0/9", halted, pc_out, imem_req, instr_valid, retire_cnt);
        end
        $display("halt: pc=%h retire=%0d halted=%b", pc_out, retire_cnt, halted);
    endtask

    task automatic test_timeout;
        imem_ack = 1'b0;
        apply_reset();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || halted !== 1'b0 || fetch_err !== 1'b0) begin
                errors++; $display("FAIL timeout_wait%0d: req=%b halted=%b err=%b required 1/0/0", i, imem_req, halted, fetch_err);
            end
        end
        tick();
        checks++;
        if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'd0) begin
            errors++; $display("FAIL timeout: err=%b halted=%b req=%b pc=%h required 1/1/0/0", fetch_err, halted, imem_req, pc_out);
        end
        $display("timeout: err=%b halted=%b", fetch_err, halted);
    endtask

    task automatic test_reset_mid_fetch;
        imem_ack = 1'b1; instr_ready = 1'b1; jump_en = 1'b1; jump_pc = 32'h20;
        apply_reset();
        rst = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (pc_out !== 32'h20 || imem_req !== 1'b1 || fetch_err !== 1'b0) begin
            errors++; $display("FAIL pre_mid_reset: pc=%h req=%b err=%b required 20/1/0", pc_out, imem_req, fetch_err);
        end
        jump_en = 1'b0; imem_ack = 1'b0; rst = 1'b1;
        tick();
        checks++;
        if (pc_out !== 32'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0 || retire_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_reset: pc=%h valid=%b req=%b retire=%0d required 0/0/0/0", pc_out, instr_valid, imem_req, retire_cnt);
        end
        rst = 1'b0; imem_ack = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr_out !== 32'd0 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL ack_ignored: req=%b valid=%b instr=%h addr=%h required 1/0/0/0", imem_req, instr_valid, instr_out, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 32'hA000_0000) begin
            errors++; $display("FAIL refetch: valid=%b instr=%h required 1/a0000000", instr_valid, instr_out);
        end
        $display("reset_mid_fetch: fresh fetch instr=%h", instr_out);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_backpressure();
        test_redirect();
        test_halt();
        test_timeout();
        test_reset_mid_fetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
